// File: rtl/sp_mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port memory with an async read path.
// Partial-byte writes take one extra read-modify-write cycle.
module sp_mem_arbiter #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH = 30
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  // port 0 (fetch)
  input  logic                    req_0_i,
  input  logic                    we_0_i,
  input  logic [ADDR_WIDTH-1:0]   addr_0_i,
  input  logic [WIDTH-1:0]        wdata_0_i,
  input  logic [WIDTH/8-1:0]      be_0_i,
  output logic                    gnt_0_o,
  output logic                    rvalid_0_o,
  output logic [WIDTH-1:0]        rdata_0_o,
  // port 1 (data)
  input  logic                    req_1_i,
  input  logic                    we_1_i,
  input  logic [ADDR_WIDTH-1:0]   addr_1_i,
  input  logic [WIDTH-1:0]        wdata_1_i,
  input  logic [WIDTH/8-1:0]      be_1_i,
  output logic                    gnt_1_o,
  output logic                    rvalid_1_o,
  output logic [WIDTH-1:0]        rdata_1_o,
  // memory side
  output logic                    mem_read_o,
  output logic [ADDR_WIDTH-1:0]   mem_raddr_o,
  input  logic [WIDTH-1:0]        mem_rdata_i,
  output logic                    mem_write_o,
  output logic [ADDR_WIDTH-1:0]   mem_waddr_o,
  output logic [WIDTH-1:0]        mem_wdata_o
);

  localparam int unsigned NB = WIDTH / 8;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RMW  = 1'b1;

  logic [0:0]            state_q, state_d;
  logic                  ptr_q, ptr_d;
  logic                  rvalid_0_q, rvalid_0_d;
  logic                  rvalid_1_q, rvalid_1_d;
  logic [WIDTH-1:0]      rdata_0_q, rdata_0_d;
  logic [WIDTH-1:0]      rdata_1_q, rdata_1_d;
  logic                  rmw_port_q, rmw_port_d;
  logic [ADDR_WIDTH-1:0] rmw_addr_q, rmw_addr_d;
  logic [WIDTH-1:0]      rmw_wdata_q, rmw_wdata_d;
  logic [NB-1:0]         rmw_be_q, rmw_be_d;

  logic                  grant;
  logic                  sel;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [WIDTH-1:0]      sel_wdata;
  logic [NB-1:0]         sel_be;
  logic [WIDTH-1:0]      merged;

  // Byte merge of latched write data over the current memory contents.
  always_comb begin
    merged = mem_rdata_i;
    for (int unsigned k = 0; k < NB; k++) begin
      if (rmw_be_q[k]) merged[k*8 +: 8] = rmw_wdata_q[k*8 +: 8];
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    rvalid_0_d  = 1'b0;
    rvalid_1_d  = 1'b0;
    rdata_0_d   = rdata_0_q;
    rdata_1_d   = rdata_1_q;
    rmw_port_d  = rmw_port_q;
    rmw_addr_d  = rmw_addr_q;
    rmw_wdata_d = rmw_wdata_q;
    rmw_be_d    = rmw_be_q;
    grant       = 1'b0;
    sel         = 1'b0;
    sel_we      = 1'b0;
    sel_addr    = '0;
    sel_wdata   = '0;
    sel_be      = '0;
    gnt_0_o     = 1'b0;
    gnt_1_o     = 1'b0;
    mem_read_o  = 1'b0;
    mem_raddr_o = '0;
    mem_write_o = 1'b0;
    mem_waddr_o = '0;
    mem_wdata_o = '0;

    // Outputs are gated by reset so it takes effect without waiting for a clock.
    if (rstn_i) begin
      case (state_q)
        S_IDLE: begin
          if (req_0_i && req_1_i) begin
            grant = 1'b1;
            sel   = ~ptr_q;
          end else if (req_0_i || req_1_i) begin
            grant = 1'b1;
            sel   = req_1_i;
          end

          if (grant) begin
            ptr_d   = sel;
            gnt_0_o = ~sel;
            gnt_1_o = sel;
            if (sel) begin
              sel_we    = we_1_i;
              sel_addr  = addr_1_i;
              sel_wdata = wdata_1_i;
              sel_be    = be_1_i;
            end else begin
              sel_we    = we_0_i;
              sel_addr  = addr_0_i;
              sel_wdata = wdata_0_i;
              sel_be    = be_0_i;
            end

            if (!sel_we || (&sel_be) || !(|sel_be)) begin
              if (sel) rvalid_1_d = 1'b1;
              else     rvalid_0_d = 1'b1;
            end

            if (!sel_we) begin
              mem_read_o  = 1'b1;
              mem_raddr_o = sel_addr;
              if (sel) rdata_1_d = mem_rdata_i;
              else     rdata_0_d = mem_rdata_i;
            end else if (&sel_be) begin
              mem_write_o = 1'b1;
              mem_waddr_o = sel_addr;
              mem_wdata_o = sel_wdata;
            end else if (|sel_be) begin
              state_d     = S_RMW;
              rmw_port_d  = sel;
              rmw_addr_d  = sel_addr;
              rmw_wdata_d = sel_wdata;
              rmw_be_d    = sel_be;
            end
          end
        end

        S_RMW: begin
          mem_read_o  = 1'b1;
          mem_raddr_o = rmw_addr_q;
          mem_write_o = 1'b1;
          mem_waddr_o = rmw_addr_q;
          mem_wdata_o = merged;
          if (rmw_port_q) rvalid_1_d = 1'b1;
          else            rvalid_0_d = 1'b1;
          state_d = S_IDLE;
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= S_IDLE;
      ptr_q       <= 1'b1;
      rvalid_0_q  <= 1'b0;
      rvalid_1_q  <= 1'b0;
      rdata_0_q   <= '0;
      rdata_1_q   <= '0;
      rmw_port_q  <= 1'b0;
      rmw_addr_q  <= '0;
      rmw_wdata_q <= '0;
      rmw_be_q    <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rvalid_0_q  <= rvalid_0_d;
      rvalid_1_q  <= rvalid_1_d;
      rdata_0_q   <= rdata_0_d;
      rdata_1_q   <= rdata_1_d;
      rmw_port_q  <= rmw_port_d;
      rmw_addr_q  <= rmw_addr_d;
      rmw_wdata_q <= rmw_wdata_d;
      rmw_be_q    <= rmw_be_d;
    end
  end

  assign rvalid_0_o = rvalid_0_q;
  assign rvalid_1_o = rvalid_1_q;
  assign rdata_0_o  = rdata_0_q;
  assign rdata_1_o  = rdata_1_q;

endmodule

// File: tb/tb_sp_mem_arbiter.sv
// Directed bench for sp_mem_arbiter: a per-cycle vector table plus hand-written
// read-modify-write and reset-abort sequences against a small behavioural memory.
module tb_sp_mem_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_0, we_0, req_1, we_1;
  logic [29:0] addr_0, addr_1;
  logic [31:0] wdata_0, wdata_1;
  logic [3:0]  be_0, be_1;
  logic        gnt_0, gnt_1, rvalid_0, rvalid_1;
  logic [31:0] rdata_0, rdata_1;
  logic        mem_read, mem_write;
  logic [29:0] mem_raddr, mem_waddr;
  logic [31:0] mem_rdata, mem_wdata;

  logic [31:0] mem [256];
  logic        bd_we = 1'b0;
  logic [7:0]  bd_addr = 8'h0;
  logic [31:0] bd_data = 32'h0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sp_mem_arbiter #(.WIDTH(32), .ADDR_WIDTH(30)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .req_0_i(req_0), .we_0_i(we_0), .addr_0_i(addr_0), .wdata_0_i(wdata_0), .be_0_i(be_0),
    .gnt_0_o(gnt_0), .rvalid_0_o(rvalid_0), .rdata_0_o(rdata_0),
    .req_1_i(req_1), .we_1_i(we_1), .addr_1_i(addr_1), .wdata_1_i(wdata_1), .be_1_i(be_1),
    .gnt_1_o(gnt_1), .rvalid_1_o(rvalid_1), .rdata_1_o(rdata_1),
    .mem_read_o(mem_read), .mem_raddr_o(mem_raddr), .mem_rdata_i(mem_rdata),
    .mem_write_o(mem_write), .mem_waddr_o(mem_waddr), .mem_wdata_o(mem_wdata)
  );

  // Behavioural memory: async read, write on rising edge, plus a backdoor preload path.
  assign mem_rdata = mem[mem_raddr[7:0]];
  always @(posedge clk) begin
    if (bd_we)          mem[bd_addr] <= bd_data;
    else if (mem_write) mem[mem_waddr[7:0]] <= mem_wdata;
  end

  typedef struct {
    logic        r0; logic w0; logic [29:0] a0; logic [31:0] d0; logic [3:0] b0;
    logic        r1; logic w1; logic [29:0] a1; logic [31:0] d1; logic [3:0] b1;
    logic        g0; logic g1; logic mr; logic mw; logic v0; logic v1;
    logic [31:0] rd0; logic [31:0] rd1;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bd_write(input logic [7:0] a, input logic [31:0] d);
    bd_addr = a;
    bd_data = d;
    bd_we   = 1'b1;
    @(posedge clk);
    #1;
    bd_we = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0;
    req_0 = 1'b0; we_0 = 1'b0; addr_0 = '0; wdata_0 = '0; be_0 = '0;
    req_1 = 1'b0; we_1 = 1'b0; addr_1 = '0; wdata_1 = '0; be_1 = '0;

    //            r0    w0    a0      d0            b0    r1    w1    a1      d1            b1    g0    g1    mr    mw    v0    v1    rd0           rd1
    vecs[0] = '{1'b1, 1'b0, 30'h10, 32'h0,        4'h0, 1'b1, 1'b0, 30'h18, 32'h0,        4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0};
    vecs[1] = '{1'b1, 1'b0, 30'h10, 32'h0,        4'h0, 1'b1, 1'b0, 30'h18, 32'h0,        4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 30'h10, 32'h0,        4'h0, 1'b1, 1'b0, 30'h18, 32'h0,        4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 32'hCAFEF00D};
    vecs[3] = '{1'b1, 1'b0, 30'h10, 32'h0,        4'h0, 1'b1, 1'b0, 30'h18, 32'h0,        4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 32'hCAFEF00D};
    vecs[4] = '{1'b0, 1'b0, 30'h0,  32'h0,        4'h0, 1'b1, 1'b1, 30'h30, 32'h55AA55AA, 4'hF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 32'hCAFEF00D};
    vecs[5] = '{1'b1, 1'b0, 30'h30, 32'h0,        4'h0, 1'b0, 1'b0, 30'h0,  32'h0,        4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 32'hCAFEF00D};
    vecs[6] = '{1'b1, 1'b1, 30'h50, 32'h12345678, 4'h0, 1'b0, 1'b0, 30'h0,  32'h0,        4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h55AA55AA, 32'hCAFEF00D};
    vecs[7] = '{1'b0, 1'b0, 30'h0,  32'h0,        4'h0, 1'b0, 1'b0, 30'h0,  32'h0,        4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h55AA55AA, 32'hCAFEF00D};
    vecs[8] = '{1'b1, 1'b0, 30'h18, 32'h0,        4'h0, 1'b0, 1'b0, 30'h0,  32'h0,        4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h55AA55AA, 32'hCAFEF00D};
    vecs[9] = '{1'b0, 1'b0, 30'h0,  32'h0,        4'h0, 1'b0, 1'b0, 30'h0,  32'h0,        4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hCAFEF00D, 32'hCAFEF00D};

    #1;
    bd_write(8'h10, 32'hDEADBEEF);
    bd_write(8'h18, 32'hCAFEF00D);
    bd_write(8'h20, 32'hFFFFFFFF);
    bd_write(8'h40, 32'h11223344);

    // Outputs stay quiet while reset is held, even with a request present.
    req_0 = 1'b1; addr_0 = 30'h10;
    #3;
    check("rst gnt_0",    32'(gnt_0),     32'h0);
    check("rst mem_read", 32'(mem_read),  32'h0);
    check("rst mem_write",32'(mem_write), 32'h0);
    check("rst rvalid_0", 32'(rvalid_0),  32'h0);
    check("rst rdata_0",  rdata_0,        32'h0);
    check("rst rdata_1",  rdata_1,        32'h0);
    next_cycle();
    rstn = 1'b1;

    for (int i = 0; i < 10; i++) begin
      req_0 = vecs[i].r0; we_0 = vecs[i].w0; addr_0 = vecs[i].a0; wdata_0 = vecs[i].d0; be_0 = vecs[i].b0;
      req_1 = vecs[i].r1; we_1 = vecs[i].w1; addr_1 = vecs[i].a1; wdata_1 = vecs[i].d1; be_1 = vecs[i].b1;
      #3;
      check($sformatf("v%0d gnt_0", i),     32'(gnt_0),     32'(vecs[i].g0));
      check($sformatf("v%0d gnt_1", i),     32'(gnt_1),     32'(vecs[i].g1));
      check($sformatf("v%0d mem_read", i),  32'(mem_read),  32'(vecs[i].mr));
      check($sformatf("v%0d mem_write", i), 32'(mem_write), 32'(vecs[i].mw));
      check($sformatf("v%0d rvalid_0", i),  32'(rvalid_0),  32'(vecs[i].v0));
      check($sformatf("v%0d rvalid_1", i),  32'(rvalid_1),  32'(vecs[i].v1));
      check($sformatf("v%0d rdata_0", i),   rdata_0,        vecs[i].rd0);
      check($sformatf("v%0d rdata_1", i),   rdata_1,        vecs[i].rd1);
      next_cycle();
    end
    req_0 = 1'b0; req_1 = 1'b0;
    check("mem30 after full write", mem[8'h30], 32'h55AA55AA);

    // Partial write from port 1, port 0 waits through the RMW cycle.
    req_1 = 1'b1; we_1 = 1'b1; addr_1 = 30'h20; wdata_1 = 32'h1234ABCD; be_1 = 4'b0011;
    #3;
    check("rmw grant gnt_1",    32'(gnt_1),     32'h1);
    check("rmw grant mem_read", 32'(mem_read),  32'h0);
    check("rmw grant mem_write",32'(mem_write), 32'h0);
    next_cycle();
    req_1 = 1'b0;
    req_0 = 1'b1; we_0 = 1'b0; addr_0 = 30'h10; be_0 = 4'h0;
    #3;
    check("rmw gnt_0",     32'(gnt_0),     32'h0);
    check("rmw gnt_1",     32'(gnt_1),     32'h0);
    check("rmw mem_read",  32'(mem_read),  32'h1);
    check("rmw mem_write", 32'(mem_write), 32'h1);
    check("rmw raddr",     32'(mem_raddr), 32'h20);
    check("rmw waddr",     32'(mem_waddr), 32'h20);
    check("rmw wdata",     mem_wdata,      32'hFFFFABCD);
    check("rmw rvalid_1",  32'(rvalid_1),  32'h0);
    next_cycle();
    #3;
    check("post rmw rvalid_1", 32'(rvalid_1), 32'h1);
    check("post rmw gnt_0",    32'(gnt_0),    32'h1);
    check("mem20 merged",      mem[8'h20],    32'hFFFFABCD);
    next_cycle();
    req_0 = 1'b0;
    #3;
    check("after rmw rvalid_0", 32'(rvalid_0), 32'h1);
    check("after rmw rdata_0",  rdata_0,       32'hDEADBEEF);
    check("after rmw rvalid_1", 32'(rvalid_1), 32'h0);
    check("after rmw rdata_1",  rdata_1,       32'hCAFEF00D);
    next_cycle();

    // Reset lands in the middle of an RMW cycle.
    req_0 = 1'b1; we_0 = 1'b1; addr_0 = 30'h40; wdata_0 = 32'hAABBCCDD; be_0 = 4'b1000;
    #3;
    check("abort grant gnt_0", 32'(gnt_0), 32'h1);
    next_cycle();
    req_0 = 1'b0;
    #1;
    check("abort in rmw", 32'(mem_write), 32'h1);
    rstn = 1'b0;
    #1;
    check("abort mem_write", 32'(mem_write), 32'h0);
    check("abort mem_read",  32'(mem_read),  32'h0);
    check("abort gnt_0",     32'(gnt_0),     32'h0);
    check("abort rvalid_0",  32'(rvalid_0),  32'h0);
    check("abort rdata_0",   rdata_0,        32'h0);
    check("abort rdata_1",   rdata_1,        32'h0);
    next_cycle();
    check("mem40 untouched", mem[8'h40], 32'h11223344);
    rstn = 1'b1;
    req_0 = 1'b1; we_0 = 1'b0; addr_0 = 30'h40; be_0 = 4'h0;
    #3;
    check("release gnt_0",    32'(gnt_0),    32'h1);
    check("release rvalid_0", 32'(rvalid_0), 32'h0);
    check("release rvalid_1", 32'(rvalid_1), 32'h0);
    next_cycle();
    req_0 = 1'b0;
    #3;
    check("release read rvalid_0", 32'(rvalid_0), 32'h1);
    check("release read rdata_0",  rdata_0,       32'h11223344);
    check("release read rvalid_1", 32'(rvalid_1), 32'h0);
    next_cycle();
    #3;
    check("rvalid_0 single pulse", 32'(rvalid_0), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
